logic_unit_arbiter: RTL and testbench

Shares one 32-bit bitwise logic datapath (AND/OR/XOR/NOR) between two requesters in the execute stage: requester 0 is the integer pipeline and requester 1 is the branch/compare helper. Arbitration is round-robin with valid/ready handshakes on both sides. The result is registered, with a single-entry output buffer and full backpressure support.

---
 rtl/alu_pkg.sv | 18 +
 rtl/logic_unit_arbiter_if.sv | 44 ++++
 rtl/logic_unit.sv | 26 ++
 rtl/logic_unit_arbiter.sv | 98 +++++++++
 tb/tb_logic_unit_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage logic datapath and its arbiter.
// Holds opcode encodings, default widths and the result-register state type.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int OPW   = 2;

    localparam logic [OPW-1:0] OP_AND = 2'b00;
    localparam logic [OPW-1:0] OP_OR  = 2'b01;
    localparam logic [OPW-1:0] OP_XOR = 2'b10;
    localparam logic [OPW-1:0] OP_NOR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the result consumer.
// The arbiter sits on the slave side; requesters and consumer drive the master side.
interface logic_unit_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
);

    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );

endinterface

// File: rtl/logic_unit.sv
// Combinational full-width bitwise datapath: AND, OR, XOR, NOR selected by opcode.
// No carry or flags; shared by both requesters through the arbiter's grant mux.
module logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: assigning a default before the case keeps y fully specified on every path, so no latch is inferred.
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between the integer pipeline (0) and
// the branch/compare helper (1), with a single registered result entry and backpressure.
module logic_unit_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus
);

    state_e           state_q,      state_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic [OPW-1:0]   mux_op;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [WIDTH-1:0] unit_y;

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_q;
        end else if (bus.req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign can_accept     = (state_q == ST_EMPTY) || bus.rsp_ready;
    assign accept         = can_accept && grant_valid;
    assign bus.req0_ready = accept && (grant_id == 1'b0);
    assign bus.req1_ready = accept && (grant_id == 1'b1);

    assign mux_op = grant_id ? bus.req1_op : bus.req0_op;
    assign mux_a  = grant_id ? bus.req1_a  : bus.req0_a;
    assign mux_b  = grant_id ? bus.req1_b  : bus.req0_b;

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op (mux_op),
        .a  (mux_a),
        .b  (mux_b),
        .y  (unit_y)
    );

    // Refill takes priority over drain so a held rsp_ready gives one result per cycle.
    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            state_d      = ST_FULL;
            rsp_id_d     = grant_id;
            rsp_data_d   = unit_y;
            last_grant_d = grant_id;
        end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: the result payload is reset along with the valid bit so a discarded in-flight result never shows on rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: opcodes, round-robin fairness, backpressure,
// drain and asynchronous reset, with hand-computed expected values.
module tb_logic_unit_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic_unit_arbiter_if #(.WIDTH(32)) bus ();

    logic_unit_arbiter #(
        .WIDTH (32),
        .OPW   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge to sample registered outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_op    = 2'b00;
        bus.req0_a     = 32'h0;
        bus.req0_b     = 32'h0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00;
        bus.req1_a     = 32'h0;
        bus.req1_b     = 32'h0;
    endtask

    logic [1:0]  op_tab  [4];
    logic [31:0] exp_tab [4];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        bus.rsp_ready = 1'b0;

        op_tab  = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
        exp_tab = '{32'h0000A5A5, 32'hA5A5FFFF, 32'hA5A55A5A, 32'h5A5A0000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_id",    32'(bus.rsp_id),    32'd0);
        check("rst_data",  bus.rsp_data,       32'h0);

        // Single op from requester 0
        @(negedge clk);
        rst_n          = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = OP_XOR;
        bus.req0_a     = 32'hFFFF0000;
        bus.req0_b     = 32'h0F0F0F0F;
        #1;
        check("t1_r0_ready", 32'(bus.req0_ready), 32'd1);
        check("t1_r1_ready", 32'(bus.req1_ready), 32'd0);
        step();
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_id",    32'(bus.rsp_id),    32'd0);
        check("t1_data",  bus.rsp_data,       32'hF0F00F0F);

        // All opcodes, alternating requesters; the idle side carries ignored garbage operands
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i[0]) begin
                bus.req1_valid = 1'b1;
                bus.req1_op    = op_tab[i];
                bus.req1_a     = 32'hA5A5A5A5;
                bus.req1_b     = 32'h0000FFFF;
                bus.req0_op    = ~op_tab[i];
                bus.req0_a     = 32'h12345678;
                bus.req0_b     = 32'h9ABCDEF0;
            end else begin
                bus.req0_valid = 1'b1;
                bus.req0_op    = op_tab[i];
                bus.req0_a     = 32'hA5A5A5A5;
                bus.req0_b     = 32'h0000FFFF;
                bus.req1_op    = ~op_tab[i];
                bus.req1_a     = 32'h12345678;
                bus.req1_b     = 32'h9ABCDEF0;
            end
            step();
            check($sformatf("t2_data_op%0d", i), bus.rsp_data, exp_tab[i]);
            check($sformatf("t2_id_op%0d", i), 32'(bus.rsp_id), 32'(i % 2));
        end

        // Drain without refill
        @(negedge clk);
        idle_inputs();
        #1;
        check("t5_r0_ready", 32'(bus.req0_ready), 32'd0);
        step();
        check("t5_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_data",  bus.rsp_data,       32'h5A5A0000);
        check("t5_id",    32'(bus.rsp_id),    32'd1);

        // Contention from reset: both valid, rsp_ready high
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = OP_AND;
        bus.req0_a     = 32'hFF00FF00;
        bus.req0_b     = 32'h0FF00FF0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = OP_OR;
        bus.req1_a     = 32'hFF00FF00;
        bus.req1_b     = 32'h0FF00FF0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t3_first_r0", 32'(bus.req0_ready), 32'd1);
        check("t3_first_r1", 32'(bus.req1_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t3_id_%0d", i),    32'(bus.rsp_id),    32'(i % 2));
            check($sformatf("t3_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("t3_data_%0d", i),  bus.rsp_data,
                  (i % 2 == 0) ? 32'h0F000F00 : 32'hFFF0FFF0);
        end

        // Drain, then backpressure: req1 result pending while req0 waits
        @(negedge clk);
        idle_inputs();
        step();
        check("t4_drained", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = OP_XOR;
        bus.req1_a     = 32'h12345678;
        bus.req1_b     = 32'hFFFFFFFF;
        #1;
        check("t4_empty_r1_ready", 32'(bus.req1_ready), 32'd1);
        step();
        check("t4_first_data", bus.rsp_data,    32'hEDCBA987);
        check("t4_first_id",   32'(bus.rsp_id), 32'd1);
        @(negedge clk);
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_op    = OP_AND;
        bus.req0_a     = 32'hDEADBEEF;
        bus.req0_b     = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_hold_r0_%0d", i), 32'(bus.req0_ready), 32'd0);
            check($sformatf("t4_hold_r1_%0d", i), 32'(bus.req1_ready), 32'd0);
            step();
            check($sformatf("t4_hold_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("t4_hold_data_%0d", i),  bus.rsp_data,       32'hEDCBA987);
            check($sformatf("t4_hold_id_%0d", i),    32'(bus.rsp_id),    32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("t4_release_r0_ready", 32'(bus.req0_ready), 32'd1);
        step();
        check("t4_new_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_new_data",  bus.rsp_data,       32'hDEAD0000);
        check("t4_new_id",    32'(bus.rsp_id),    32'd0);

        // Asynchronous reset while FULL and stalled; requester 0 granted last before it
        @(negedge clk);
        idle_inputs();
        bus.rsp_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_async_data",  bus.rsp_data,       32'h0);
        check("t6_async_id",    32'(bus.rsp_id),    32'd0);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = OP_OR;
        bus.req0_a     = 32'h00000F00;
        bus.req0_b     = 32'h000000F0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = OP_NOR;
        bus.req1_a     = 32'h0;
        bus.req1_b     = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_r0_first", 32'(bus.req0_ready), 32'd1);
        check("t6_r1_wait",  32'(bus.req1_ready), 32'd0);
        step();
        check("t6_id0",   32'(bus.rsp_id), 32'd0);
        check("t6_data0", bus.rsp_data,    32'h00000FF0);
        step();
        check("t6_id1",   32'(bus.rsp_id), 32'd1);
        check("t6_data1", bus.rsp_data,    32'hFFFFFFFF);

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
